// File: rtl/mod_counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mod_ctrl_pkg
// Description : Shared types and reset defaults for the modulo-N counter
//               sequencer (mod_counter_ctrl) and its counting core.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents
//   state_e       sequencer state encoding (IDLE / RUN / PAUSE / DONE)
//   DEF_TERM      terminal value loaded at reset (modulus 7)
//   DEF_ROUNDS    round count loaded at reset
//   st_busy()     state is RUN or PAUSE
//   st_cfg_open() state accepts a new configuration (IDLE or DONE)
// ============================================================================
package mod_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_TERM   = 6;
    localparam int DEF_ROUNDS = 1;

    function automatic logic st_busy(input state_e s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

    function automatic logic st_cfg_open(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage : mod_ctrl_pkg
`default_nettype wire

// File: rtl/mod_counter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : mod_counter_ctrl_if
// Description : Config handshake, run controls and status of the modulo-N
//               counter sequencer, bundled for the control/test logic
//               (master) and the sequencer (slave).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   cfg_valid  m->s  config offer
//   cfg_ready  s->m  config accepted when cfg_valid & cfg_ready
//   cfg_term   m->s  terminal value = modulus-1 (0 is illegal)
//   cfg_rounds m->s  full cycles before done; 0 = free-running
//   start      m->s  start (IDLE) or resume (PAUSE)
//   stop       m->s  pause (RUN) or abort (PAUSE)
//   done_ack   m->s  clears done, returns to IDLE
//   dir        m->s  count direction, only with MODCTL_DOWN_EN defined
//   count      s->m  current count
//   wrap       s->m  terminal-count pulse
//   busy       s->m  RUN or PAUSE
//   done       s->m  DONE
//   err        s->m  last accepted config had cfg_term==0
// Configuration macro: MODCTL_DOWN_EN (adds dir)
// ============================================================================
interface mod_counter_ctrl_if #(
    parameter int WIDTH  = 3,
    parameter int RWIDTH = 4
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WIDTH-1:0]  cfg_term;
    logic [RWIDTH-1:0] cfg_rounds;
    logic              start;
    logic              stop;
    logic              done_ack;
`ifdef MODCTL_DOWN_EN
    logic              dir;
`endif
    logic [WIDTH-1:0]  count;
    logic              wrap;
    logic              busy;
    logic              done;
    logic              err;

`ifdef MODCTL_DOWN_EN
    modport master (
        output cfg_valid, cfg_term, cfg_rounds, start, stop, done_ack, dir,
        input  cfg_ready, count, wrap, busy, done, err
    );
    modport slave (
        input  cfg_valid, cfg_term, cfg_rounds, start, stop, done_ack, dir,
        output cfg_ready, count, wrap, busy, done, err
    );
`else
    modport master (
        output cfg_valid, cfg_term, cfg_rounds, start, stop, done_ack,
        input  cfg_ready, count, wrap, busy, done, err
    );
    modport slave (
        input  cfg_valid, cfg_term, cfg_rounds, start, stop, done_ack,
        output cfg_ready, count, wrap, busy, done, err
    );
`endif

endinterface : mod_counter_ctrl_if
`default_nettype wire

// File: rtl/mod_counter_core.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter_core
// Description : Modulo-N count register. Sync clear, parallel load and an
//               enabled step that wraps at the terminal value in either
//               direction.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, rising edge
//   clr        in   asynchronous active-low reset
//   en_i       in   advance one step
//   sclr_i     in   synchronous clear to 0 (highest priority)
//   load_i     in   load load_val_i (beats en_i)
//   load_val_i in   value for load_i
//   term_i     in   terminal value (modulus-1)
//   down_i     in   1: count down, terminal is 0, wraps to term_i
//   count_o    out  current count
//   at_term_o  out  count is at the terminal point for the direction
// ============================================================================
module mod_counter_core #(
    parameter int WIDTH = 3
) (
    input  wire logic             clk,
    input  wire logic             clr,
    input  wire logic             en_i,
    input  wire logic             sclr_i,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    input  wire logic [WIDTH-1:0] term_i,
    input  wire logic             down_i,
    output logic      [WIDTH-1:0] count_o,
    output logic                  at_term_o
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_term;

    // Up: terminal is term_i. Down: terminal is 0. A term of all ones
    // still works because the +1 rolls over to 0 on its own.
    assign at_term = down_i ? (count_q == '0) : (count_q == term_i);

    always_comb begin
        count_d = count_q;
        if (sclr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            if (down_i) begin
                count_d = at_term ? term_i : (count_q - C_ONE);
            end else begin
                count_d = at_term ? '0 : (count_q + C_ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign at_term_o = at_term;

endmodule : mod_counter_core
`default_nettype wire

// File: rtl/mod_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter_ctrl
// Description : Sequencer for a programmable modulo-N counter. Accepts a
//               modulus and round count over a valid/ready port, then starts,
//               pauses, stops and terminates the count. Pulses wrap at each
//               terminal count and holds done after the last round.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     count width; modulus range 2..2**WIDTH
//   RWIDTH    round counter width
//   DEF_TERM  terminal value loaded at reset
// Ports
//   clk   in     clock, rising edge
//   clr   in     asynchronous active-low reset
//   bus   slave  mod_counter_ctrl_if (config, controls, status)
// Configuration macro
//   MODCTL_DOWN_EN  adds bus.dir, sampled when start leaves IDLE; dir=1
//                   counts down from term and wraps 0->term.
// ============================================================================
module mod_counter_ctrl #(
    parameter int WIDTH    = 3,
    parameter int RWIDTH   = 4,
    parameter int DEF_TERM = mod_ctrl_pkg::DEF_TERM
) (
    input  wire logic         clk,
    input  wire logic         clr,
    mod_counter_ctrl_if.slave bus
);

    import mod_ctrl_pkg::*;

    localparam logic [WIDTH-1:0]  C_DEF_TERM   = WIDTH'(DEF_TERM);
    localparam logic [RWIDTH-1:0] C_DEF_ROUNDS = RWIDTH'(mod_ctrl_pkg::DEF_ROUNDS);
    localparam logic [RWIDTH-1:0] C_R_ONE      = RWIDTH'(1);

    state_e            state_q;
    state_e            state_d;
    logic              busy_q;
    logic              done_q;
    logic              cfg_ready_q;

    logic [WIDTH-1:0]  term_q;
    logic [RWIDTH-1:0] rounds_q;
    logic [RWIDTH-1:0] rem_q;
    logic [RWIDTH-1:0] rem_d;
    logic              err_q;

    logic              core_en;
    logic              core_sclr;
    logic              core_load;
    logic [WIDTH-1:0]  core_load_val;
    logic [WIDTH-1:0]  count;
    logic              at_term;
    logic              down;
    logic              go;
    logic              cfg_fire;

    // stop beats start, so a simultaneous pair never launches from IDLE
    assign go       = bus.start && !bus.stop;
    assign cfg_fire = bus.cfg_valid && cfg_ready_q;

`ifdef MODCTL_DOWN_EN
    logic dir_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dir_q <= 1'b0;
        end else if (state_q == ST_IDLE && go) begin
            dir_q <= bus.dir;
        end
    end

    // During the launch cycle the live dir selects the load value; the
    // sampled copy governs the rest of the run.
    assign down          = (state_q == ST_IDLE) ? bus.dir : dir_q;
    assign core_load_val = bus.dir ? term_q : '0;
`else
    assign down          = 1'b0;
    assign core_load_val = '0;
`endif

    mod_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .clr        (clr),
        .en_i       (core_en),
        .sclr_i     (core_sclr),
        .load_i     (core_load),
        .load_val_i (core_load_val),
        .term_i     (term_q),
        .down_i     (down),
        .count_o    (count),
        .at_term_o  (at_term)
    );

    // Next state and counter controls. The stop cycle in RUN does not step
    // the count, so a pause freezes exactly the value seen when stop hit.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        core_en   = 1'b0;
        core_sclr = 1'b0;
        core_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d   = ST_RUN;
                    core_load = 1'b1;
                    rem_d     = rounds_q;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_PAUSE;
                end else begin
                    core_en = 1'b1;
                    // rem_q == 0 is free-running: never decremented
                    if (at_term && rem_q != '0) begin
                        rem_d = rem_q - C_R_ONE;
                        if (rem_q == C_R_ONE) begin
                            state_d   = ST_DONE;
                            core_sclr = 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    state_d   = ST_IDLE;
                    core_sclr = 1'b1;
                    rem_d     = rounds_q;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.done_ack) begin
                    state_d = ST_IDLE;
                    rem_d   = rounds_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                core_sclr = 1'b1;
            end
        endcase
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_IDLE;
            rem_q       <= C_DEF_ROUNDS;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            busy_q      <= st_busy(state_d);
            done_q      <= (state_d == ST_DONE);
            cfg_ready_q <= st_cfg_open(state_d);
        end
    end

    // A zero terminal would be modulus 1; reject it but keep the last
    // good setting so the counter stays usable.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            term_q   <= C_DEF_TERM;
            rounds_q <= C_DEF_ROUNDS;
            err_q    <= 1'b0;
        end else if (cfg_fire) begin
            if (bus.cfg_term == '0) begin
                err_q <= 1'b1;
            end else begin
                term_q   <= bus.cfg_term;
                rounds_q <= bus.cfg_rounds;
                err_q    <= 1'b0;
            end
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.count     = count;
    assign bus.wrap      = (state_q == ST_RUN) && at_term;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule : mod_counter_ctrl
`default_nettype wire

// File: tb/tb_mod_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_counter_ctrl
// Description : Directed self-checking bench for mod_counter_ctrl with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_counter_ctrl;

    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wraps;

    always #5 clk = ~clk;

    mod_counter_ctrl_if #(.WIDTH(3), .RWIDTH(4)) bus ();

    mod_counter_ctrl #(
        .WIDTH    (3),
        .RWIDTH   (4),
        .DEF_TERM (6)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] term, input logic [3:0] rounds);
        bus.cfg_valid  = 1'b1;
        bus.cfg_term   = term;
        bus.cfg_rounds = rounds;
        tick();
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic abort();
        bus.stop = 1'b1;
        tick();
        tick();
        bus.stop = 1'b0;
    endtask

    initial begin
        clr            = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_term   = '0;
        bus.cfg_rounds = '0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.done_ack   = 1'b0;
`ifdef MODCTL_DOWN_EN
        bus.dir        = 1'b0;
`endif
        #12;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_wrap", 32'(bus.wrap), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_ready", 32'(bus.cfg_ready), 32'd1);
        clr = 1'b1;
        tick();

        // T1: defaults (term 6, one round)
        pulse_start();
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_ready_run", 32'(bus.cfg_ready), 32'd0);
        for (int i = 0; i < 7; i++) begin
            chk("t1_count", 32'(bus.count), 32'(i));
            chk("t1_wrap", 32'(bus.wrap), 32'(i == 6));
            tick();
        end
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_done_count", 32'(bus.count), 32'd0);
        chk("t1_done_busy", 32'(bus.busy), 32'd0);
        chk("t1_done_ready", 32'(bus.cfg_ready), 32'd1);
        bus.done_ack = 1'b1;
        tick();
        bus.done_ack = 1'b0;
        chk("t1_ack_done", 32'(bus.done), 32'd0);

        // T2: term 4, three rounds
        cfg(3'd4, 4'd3);
        chk("t2_err", 32'(bus.err), 32'd0);
        pulse_start();
        wraps = 0;
        for (int i = 0; i < 15; i++) begin
            chk("t2_count", 32'(bus.count), 32'(i % 5));
            chk("t2_done_low", 32'(bus.done), 32'd0);
            if (bus.wrap) wraps++;
            tick();
        end
        chk("t2_wraps", 32'(wraps), 32'd3);
        chk("t2_done", 32'(bus.done), 32'd1);
        tick();
        tick();
        chk("t2_done_held", 32'(bus.done), 32'd1);
        bus.done_ack = 1'b1;
        tick();
        bus.done_ack = 1'b0;
        chk("t2_ack_done", 32'(bus.done), 32'd0);
        chk("t2_ack_busy", 32'(bus.busy), 32'd0);

        // T3: free-running, pause at 3 and resume
        cfg(3'd6, 4'd0);
        pulse_start();
        tick();
        tick();
        tick();
        chk("t3_pre_stop", 32'(bus.count), 32'd3);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("t3_pause_busy", 32'(bus.busy), 32'd1);
        chk("t3_pause_wrap", 32'(bus.wrap), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_frozen", 32'(bus.count), 32'd3);
            tick();
        end
        pulse_start();
        chk("t3_resume", 32'(bus.count), 32'd3);
        tick();
        chk("t3_next", 32'(bus.count), 32'd4);
        tick();
        tick();
        chk("t3_wrap", 32'(bus.wrap), 32'd1);
        tick();
        chk("t3_wrapped", 32'(bus.count), 32'd0);
        chk("t3_no_done", 32'(bus.done), 32'd0);
        chk("t3_free_busy", 32'(bus.busy), 32'd1);
        abort();
        chk("t3_abort_busy", 32'(bus.busy), 32'd0);
        chk("t3_abort_count", 32'(bus.count), 32'd0);
        chk("t3_abort_ready", 32'(bus.cfg_ready), 32'd1);

        // T4: illegal term keeps previous config, then a legal one
        cfg(3'd0, 4'd5);
        chk("t4_err_set", 32'(bus.err), 32'd1);
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            chk("t4_old_term", 32'(bus.count), 32'(i));
            tick();
        end
        chk("t4_old_rounds", 32'(bus.done), 32'd0);
        chk("t4_old_wrapped", 32'(bus.count), 32'd0);
        abort();
        cfg(3'd2, 4'd1);
        chk("t4_err_clr", 32'(bus.err), 32'd0);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            chk("t4_count", 32'(bus.count), 32'(i));
            chk("t4_wrap", 32'(bus.wrap), 32'(i == 2));
            tick();
        end
        chk("t4_done", 32'(bus.done), 32'd1);
        bus.done_ack = 1'b1;
        tick();
        bus.done_ack = 1'b0;

        // T5: start+stop in RUN pauses; config offered in RUN ignored; reset
        cfg(3'd6, 4'd0);
        pulse_start();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        tick();
        chk("t5_paused", 32'(bus.count), 32'd0);
        chk("t5_paused_busy", 32'(bus.busy), 32'd1);
        pulse_start();
        bus.cfg_valid  = 1'b1;
        bus.cfg_term   = 3'd2;
        bus.cfg_rounds = 4'd1;
        chk("t5_ready_run", 32'(bus.cfg_ready), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        bus.cfg_valid = 1'b0;
        chk("t5_count5", 32'(bus.count), 32'd5);
        #2;
        clr = 1'b0;
        #1;
        chk("t5_rst_count", 32'(bus.count), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_ready", 32'(bus.cfg_ready), 32'd1);
        #1;
        clr = 1'b1;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            chk("t5_def_term", 32'(bus.count), 32'(i));
            tick();
        end
        chk("t5_def_done", 32'(bus.done), 32'd1);
        bus.done_ack = 1'b1;
        tick();
        bus.done_ack = 1'b0;

`ifdef MODCTL_DOWN_EN
        // T6: down count
        cfg(3'd6, 4'd0);
        bus.dir = 1'b1;
        pulse_start();
        bus.dir = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            chk("t6_count", 32'(bus.count), 32'(i));
            chk("t6_wrap", 32'(bus.wrap), 32'(i == 0));
            tick();
        end
        chk("t6_reload", 32'(bus.count), 32'd6);
        chk("t6_ready_run", 32'(bus.cfg_ready), 32'd0);
        abort();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mod_counter_ctrl
`default_nettype wire
